hqm_aw_rtdr_tap_ctl: RTL and testbench

IEEE 1149.1-style TAP controller that sequences a bank of NUM_RTDR remote TDR registers.
- Runs the 16-state TAP FSM from tms.
- Holds the instruction register (IR) and decodes it into one-hot irdec selects.
- Generates the shiftdr, capturedr and updatedr strobes.
- Muxes the serial tdo from the IR, the bypass bit, or the selected RTDR.
- Sits between the chip-level TAP pins and the per-function RTDR instances.

---
 rtl/hqm_aw_rtdr_tap_ctl.sv | 120 ++++++++++++
 tb/tb_hqm_aw_rtdr_tap_ctl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_aw_rtdr_tap_ctl.sv
// TAP controller sequencing a bank of remote TDRs: 16-state FSM, IR,
// one-hot RTDR select, DR strobes and the serial tdo mux.
module hqm_aw_rtdr_tap_ctl #(
  parameter int IR_WIDTH = 8,
  parameter int NUM_RTDR = 4,
  parameter logic [IR_WIDTH-1:0] IR_RESET = '1,
  parameter logic [IR_WIDTH-1:0] RTDR_OPCODE_BASE = IR_WIDTH'('h10)
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  input  logic [NUM_RTDR-1:0] rtdr_tdo,
  output logic [NUM_RTDR-1:0] irdec,
  output logic                shiftdr,
  output logic                capturedr,
  output logic                updatedr,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SELDR   = 4'h7,
    CAPDR   = 4'h6,
    SHDR    = 4'h2,
    EX1DR   = 4'h1,
    PAUSEDR = 4'h3,
    EX2DR   = 4'h0,
    UPDDR   = 4'h5,
    SELIR   = 4'h4,
    CAPIR   = 4'hE,
    SHIR    = 4'hA,
    EX1IR   = 4'h9,
    PAUSEIR = 4'hB,
    EX2IR   = 4'h8,
    UPDIR   = 4'hD
  } tap_state_e;

  tap_state_e          state_q;
  tap_state_e          state_d;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                bypass;
  logic                sel_any;
  logic                is_shdr;
  logic                is_shir;

  always_ff @(posedge tck) begin
    if (trst) state_q <= TLR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:     state_d = tms ? TLR   : RTI;
      RTI:     state_d = tms ? SELDR : RTI;
      SELDR:   state_d = tms ? SELIR : CAPDR;
      CAPDR:   state_d = tms ? EX1DR : SHDR;
      SHDR:    state_d = tms ? EX1DR : SHDR;
      EX1DR:   state_d = tms ? UPDDR : PAUSEDR;
      PAUSEDR: state_d = tms ? EX2DR : PAUSEDR;
      EX2DR:   state_d = tms ? UPDDR : SHDR;
      UPDDR:   state_d = tms ? SELDR : RTI;
      SELIR:   state_d = tms ? TLR   : CAPIR;
      CAPIR:   state_d = tms ? EX1IR : SHIR;
      SHIR:    state_d = tms ? EX1IR : SHIR;
      EX1IR:   state_d = tms ? UPDIR : PAUSEIR;
      PAUSEIR: state_d = tms ? EX2IR : PAUSEIR;
      EX2IR:   state_d = tms ? UPDIR : SHIR;
      UPDIR:   state_d = tms ? SELDR : RTI;
    endcase
  end

  // TLR keeps forcing the reset opcode so it behaves like trst
  always_ff @(posedge tck) begin
    if (trst) begin
      ir_q   <= IR_RESET;
      ir_sr  <= '0;
      bypass <= 1'b0;
    end else begin
      case (state_q)
        TLR:     ir_q   <= IR_RESET;
        CAPIR:   ir_sr  <= IR_WIDTH'(2'b01);
        SHIR:    ir_sr  <= {tdi, ir_sr[IR_WIDTH-1:1]};
        UPDIR:   ir_q   <= ir_sr;
        CAPDR:   bypass <= 1'b0;
        SHDR:    bypass <= tdi;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RTDR; i++) begin : g_dec
    assign irdec[i] = (ir_q == RTDR_OPCODE_BASE + IR_WIDTH'(i));
  end

  assign sel_any   = |irdec;
  assign is_shdr   = (state_q == SHDR);
  assign is_shir   = (state_q == SHIR);
  assign shiftdr   = is_shdr;
  assign capturedr = (state_q == CAPDR);
  assign updatedr  = (state_q == UPDDR);
  assign tdo_en    = is_shdr | is_shir;
  assign tap_state = state_q;

  always_comb begin
    tdo = 1'b0;
    unique case (1'b1)
      is_shir:             tdo = ir_sr[0];
      is_shdr && sel_any:  tdo = |(irdec & rtdr_tdo);
      is_shdr && !sel_any: tdo = bypass;
      default:             ;
    endcase
  end

endmodule

// File: tb/tb_hqm_aw_rtdr_tap_ctl.sv
// Bench for hqm_aw_rtdr_tap_ctl: scan-chain queue model, 32-bit RTDR
// models on each select, per-cycle scoreboard plus directed checks.
module tb_hqm_aw_rtdr_tap_ctl;
  localparam int IW = 8;
  localparam int NR = 4;
  localparam int DW = 32;

  logic tck = 1'b0;
  logic trst = 1'b0;
  logic tms = 1'b0;
  logic tdi = 1'b0;
  logic [NR-1:0] rtdr_tdo;
  logic [NR-1:0] irdec;
  logic shiftdr, capturedr, updatedr, tdo, tdo_en;
  logic [IW-1:0] ir_q;
  logic [3:0] tap_state;

  always #5 tck = ~tck;

  hqm_aw_rtdr_tap_ctl dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi),
    .rtdr_tdo(rtdr_tdo), .irdec(irdec), .shiftdr(shiftdr),
    .capturedr(capturedr), .updatedr(updatedr), .tdo(tdo),
    .tdo_en(tdo_en), .ir_q(ir_q), .tap_state(tap_state)
  );

  function automatic logic [DW-1:0] capv(input int i);
    return DW'(32'hC3A5_0F1E ^ (32'h1357_9BDF * (i + 1)));
  endfunction

  // RTDR instances the controller drives
  logic [DW-1:0] rsr [NR];
  logic [DW-1:0] rpo [NR];
  always @(posedge tck) begin
    for (int i = 0; i < NR; i++) begin
      if (trst) begin
        rsr[i] <= '0;
        rpo[i] <= '0;
      end else begin
        if (irdec[i] && capturedr) rsr[i] <= capv(i);
        else if (irdec[i] && shiftdr) rsr[i] <= {tdi, rsr[i][DW-1:1]};
        if (irdec[i] && updatedr) rpo[i] <= rsr[i];
      end
    end
  end
  always_comb begin
    rtdr_tdo = '0;
    for (int i = 0; i < NR; i++) rtdr_tdo[i] = rsr[i][0];
  end

  // next state per encoding, tms=0 / tms=1
  int n0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int n1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  typedef struct packed {
    logic [3:0] st;
    logic [IW-1:0] ir;
    logic [NR-1:0] dec;
    logic sh;
    logic cap;
    logic upd;
    logic tdo;
    logic en;
    logic [NR*DW-1:0] po;
  } exp_t;

  typedef struct {
    string nm;
    logic [63:0] act;
    logic [63:0] exp;
  } dchk_t;

  exp_t sbq[$];
  dchk_t dq[$];

  int ms;
  logic [IW-1:0] mir;
  bit irq[$];
  bit mq[$];
  logic [DW-1:0] mpo [NR];
  bit mvalid = 0;
  int c_sh, c_cap, c_upd;
  int n_tot = 0;
  int n_pass = 0;

  function automatic int sel_of(input logic [IW-1:0] ir);
    int s = -1;
    for (int i = 0; i < NR; i++) if (ir == IW'(16 + i)) s = i;
    return s;
  endfunction

  function automatic logic [NR*DW-1:0] pack_m();
    logic [NR*DW-1:0] p;
    for (int i = 0; i < NR; i++) p[i*DW +: DW] = mpo[i];
    return p;
  endfunction

  task automatic model_step(input bit t, input bit d, input bit r);
    int s;
    bit b;
    logic [DW-1:0] cv;
    if (r) begin
      ms = 15;
      mir = '1;
      irq.delete();
      for (int k = 0; k < IW; k++) irq.push_back(1'b0);
      mq.delete();
      mq.push_back(1'b0);
      for (int i = 0; i < NR; i++) mpo[i] = '0;
      mvalid = 1;
      return;
    end
    case (ms)
      15: mir = '1;
      14: begin
        irq.delete();
        irq.push_back(1'b1);
        for (int k = 1; k < IW; k++) irq.push_back(1'b0);
      end
      10: begin
        b = irq.pop_front();
        irq.push_back(d);
      end
      13: for (int k = 0; k < IW; k++) mir[k] = irq[k];
      6: begin
        s = sel_of(mir);
        mq.delete();
        if (s < 0) mq.push_back(1'b0);
        else begin
          cv = capv(s);
          for (int k = 0; k < DW; k++) mq.push_back(cv[k]);
        end
      end
      2: begin
        b = mq.pop_front();
        mq.push_back(d);
      end
      5: begin
        s = sel_of(mir);
        if (s >= 0) for (int k = 0; k < DW; k++) mpo[s][k] = mq[k];
      end
      default: ;
    endcase
    ms = t ? n1[ms] : n0[ms];
  endtask

  task automatic cyc(input bit t, input bit d, input bit r = 1'b0);
    exp_t e;
    int s;
    tms = t;
    tdi = d;
    trst = r;
    if (shiftdr === 1'b1) c_sh++;
    if (capturedr === 1'b1) c_cap++;
    if (updatedr === 1'b1) c_upd++;
    if (mvalid) begin
      s = sel_of(mir);
      e.st = 4'(ms);
      e.ir = mir;
      e.dec = '0;
      if (s >= 0) e.dec[s] = 1'b1;
      e.sh = (ms == 2);
      e.cap = (ms == 6);
      e.upd = (ms == 5);
      e.en = (ms == 2) || (ms == 10);
      e.tdo = (ms == 10) ? irq[0] : (ms == 2) ? mq[0] : 1'b0;
      e.po = pack_m();
      sbq.push_back(e);
    end
    model_step(t, d, r);
    @(posedge tck);
    #1;
  endtask

  task automatic dcheck(input string nm, input logic [63:0] a,
                        input logic [63:0] e);
    dchk_t c;
    c.nm = nm;
    c.act = a;
    c.exp = e;
    dq.push_back(c);
  endtask

  always @(negedge tck) begin
    exp_t e;
    exp_t a;
    dchk_t c;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a.st = tap_state;
      a.ir = ir_q;
      a.dec = irdec;
      a.sh = shiftdr;
      a.cap = capturedr;
      a.upd = updatedr;
      a.tdo = tdo;
      a.en = tdo_en;
      for (int i = 0; i < NR; i++) a.po[i*DW +: DW] = rpo[i];
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL scoreboard t=%0t got st=%h ir=%h dec=%b sh%b cap%b upd%b tdo%b en%b po=%h want st=%h ir=%h dec=%b sh%b cap%b upd%b tdo%b en%b po=%h",
        $time, a.st, a.ir, a.dec, a.sh, a.cap, a.upd, a.tdo, a.en, a.po,
        e.st, e.ir, e.dec, e.sh, e.cap, e.upd, e.tdo, e.en, e.po);
    end
    while (dq.size() > 0) begin
      c = dq.pop_front();
      n_tot++;
      if (c.act === c.exp) n_pass++;
      else $display("FAIL %s got %h want %h", c.nm, c.act, c.exp);
    end
  end

  task automatic goto_rti();
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IW-1:0] op, output logic [IW-1:0] tb);
    tb = '0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < IW; k++) begin
      tb[k] = tdo;
      cyc(k == IW - 1, op[k]);
    end
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] data, input int pa,
                         input int plen, output logic [63:0] tb);
    bit t;
    tb = '0;
    c_sh = 0;
    c_cap = 0;
    c_upd = 0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      tb[k] = tdo;
      t = (k == n - 1) || (k == pa - 1);
      cyc(t, data[k]);
      if (k == pa - 1 && k != n - 1) begin
        cyc(1'b0, 1'b0);
        for (int p = 1; p < plen; p++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
      end
    end
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    logic [IW-1:0] irb;
    logic [63:0] tb, dat, dat2;
    int n, pa;

    cyc(1'b0, 1'b0, 1'b1);
    dcheck("reset_state", 64'(tap_state), 64'hF);
    dcheck("reset_ir", 64'(ir_q), 64'hFF);
    dcheck("reset_irdec", 64'(irdec), 64'h0);
    dcheck("reset_tdo_en", 64'(tdo_en), 64'h0);
    cyc(1'b0, 1'b0);

    load_ir(8'h11, irb);
    dcheck("ir_shift_tdo", 64'(irb), 64'h01);
    dcheck("ir_load_ir_q", 64'(ir_q), 64'h11);
    dcheck("ir_load_irdec", 64'(irdec), 64'h2);

    dat = {32'h0, $urandom};
    dr_scan(32, dat, 0, 1, tb);
    dcheck("dr1_capturedr", 64'(c_cap), 64'd1);
    dcheck("dr1_shiftdr", 64'(c_sh), 64'd32);
    dcheck("dr1_updatedr", 64'(c_upd), 64'd1);
    dcheck("dr1_tdo", tb[31:0], 64'(capv(1)));
    dcheck("dr1_func_po", 64'(rpo[1]), dat[31:0]);

    load_ir(8'hFF, irb);
    dr_scan(4, 64'hD, 0, 1, tb);
    dcheck("bypass_tdo", tb[3:0], 64'hA);
    dcheck("bypass_irdec", 64'(irdec), 64'h0);

    load_ir(8'h12, irb);
    dat2 = {32'h0, $urandom};
    dr_scan(32, dat2, 13, 5, tb);
    dcheck("pause_shiftdr", 64'(c_sh), 64'd32);
    dcheck("pause_func_po", 64'(rpo[2]), dat2[31:0]);

    load_ir(8'h13, irb);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
    dcheck("escape_state", 64'(tap_state), 64'hF);
    cyc(1'b1, 1'b0);
    dcheck("escape_ir", 64'(ir_q), 64'hFF);
    dcheck("escape_rtdr0", 64'(rpo[0]), 64'h0);
    dcheck("escape_rtdr2", 64'(rpo[2]), dat2[31:0]);

    cyc(1'b0, 1'b0);
    load_ir(8'h10, irb);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    dcheck("trst_ir_state", 64'(tap_state), 64'hF);
    dcheck("trst_ir_q", 64'(ir_q), 64'hFF);
    cyc(1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: irb = IW'(8'h10 + $urandom_range(0, NR - 1));
        4: irb = 8'hFF;
        default: irb = IW'($urandom);
      endcase
      load_ir(irb, irb);
      n = $urandom_range(1, 40);
      pa = $urandom_range(0, n);
      dat = {$urandom, $urandom};
      dr_scan(n, dat, pa, $urandom_range(1, 6), tb);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 16; k++)
          cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 63) == 0));
      end
      goto_rti();
    end

    @(negedge tck);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
